// File: rtl/sudoku_pkg.sv
// Shared types and constants for the sudoku board datapath: grid geometry,
// controller state encoding and cursor direction codes.
package sudoku_pkg;

  localparam int GRID_N = 9;
  localparam int CELL_W = 7;
  localparam int RC_W   = 4;
  localparam int CNT_W  = 25;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_e;

  // Values double as bit positions in the per-button press/level vectors.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  function automatic dir_e pick_dir(input logic [3:0] press);
    if (press[0])      return DIR_UP;
    else if (press[1]) return DIR_DOWN;
    else if (press[2]) return DIR_LEFT;
    else               return DIR_RIGHT;
  endfunction

endpackage

// File: rtl/cursor_ctrl_btn_edge.sv
// Button front end: one capture register, one previous-value register and
// a rising-edge press flag (q & ~p).
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic q_o,
  output logic press_o
);

  logic q_q;
  logic p_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q <= 1'b0;
      p_q <= 1'b0;
    end else begin
      q_q <= btn_i;
      p_q <= q_q;
    end
  end

  assign q_o     = q_q;
  assign press_o = q_q & ~p_q;

endmodule

// File: rtl/cursor_ctrl.sv
// 9x9 board cursor with registered linear cell index and select strobe.
// Optional auto-repeat on a held direction is enabled by CURSOR_AUTOREPEAT_EN.
module cursor_ctrl
  import sudoku_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              btn_sel,
  output logic [RC_W-1:0]   row,
  output logic [RC_W-1:0]   col,
  output logic [CELL_W-1:0] cell_idx,
  output logic              load
);

  if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_cfg_invalid
    $error("cursor_ctrl: HOLD_CYCLES and REPEAT_CYCLES must be at least 1");
  end

  logic [4:0] btn_raw, btn_q, btn_press;
  assign btn_raw = {btn_sel, btn_right, btn_left, btn_down, btn_up};

  for (genvar i = 0; i < 5; i++) begin : g_btn
    btn_edge u_edge (
      .clk    (clk),
      .reset  (reset),
      .btn_i  (btn_raw[i]),
      .q_o    (btn_q[i]),
      .press_o(btn_press[i])
    );
  end

  state_e            state_q, state_d;
  dir_e              dir_q, dir_d, move_dir;
  logic              do_move, held, sel_press;
  logic [RC_W-1:0]   row_q, row_d, col_q, col_d;
  logic [CELL_W-1:0] cell_q, cell_d;
  logic              load_q, load_d;
`ifdef CURSOR_AUTOREPEAT_EN
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

  assign sel_press = btn_press[4];
  assign held      = btn_q[{1'b0, dir_q}];

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    load_d   = 1'b0;
    do_move  = 1'b0;
    move_dir = dir_q;
`ifdef CURSOR_AUTOREPEAT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (sel_press) begin
          load_d = 1'b1;
        end else if (|btn_press[3:0]) begin
          do_move  = 1'b1;
          move_dir = pick_dir(btn_press[3:0]);
          dir_d    = move_dir;
          state_d  = HOLD;
`ifdef CURSOR_AUTOREPEAT_EN
          cnt_d    = '0;
`endif
        end
      end
      HOLD: begin
        // A select while holding only strobes; state and counter freeze.
        if (sel_press) begin
          load_d = 1'b1;
        end else if (!held) begin
          state_d = IDLE;
`ifdef CURSOR_AUTOREPEAT_EN
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          do_move = 1'b1;
          state_d = REPEAT;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
`endif
        end
      end
`ifdef CURSOR_AUTOREPEAT_EN
      REPEAT: begin
        if (sel_press) begin
          load_d = 1'b1;
        end else if (!held) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(REPEAT_CYCLES - 1)) begin
          do_move = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Move with per-axis wrap; the index is built from the next row/col so it
  // updates on the same edge as the cursor.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (do_move) begin
      case (move_dir)
        DIR_UP:    row_d = (row_q == '0) ? RC_W'(GRID_N - 1) : row_q - RC_W'(1);
        DIR_DOWN:  row_d = (row_q == RC_W'(GRID_N - 1)) ? '0 : row_q + RC_W'(1);
        DIR_LEFT:  col_d = (col_q == '0) ? RC_W'(GRID_N - 1) : col_q - RC_W'(1);
        default:   col_d = (col_q == RC_W'(GRID_N - 1)) ? '0 : col_q + RC_W'(1);
      endcase
    end
    cell_d = (CELL_W'(row_d) << 3) + CELL_W'(row_d) + CELL_W'(col_d);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      dir_q   <= DIR_UP;
      row_q   <= '0;
      col_q   <= '0;
      cell_q  <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cell_q  <= cell_d;
      load_q  <= load_d;
    end
  end

`ifdef CURSOR_AUTOREPEAT_EN
  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign row      = row_q;
  assign col      = col_q;
  assign cell_idx = cell_q;
  assign load     = load_q;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Directed self-checking bench for cursor_ctrl; auto-repeat scenario is
// exercised when CURSOR_AUTOREPEAT_EN is defined.
module tb_cursor_ctrl;
  import sudoku_pkg::*;

  logic       clk;
  logic       reset;
  logic       btn_up, btn_down, btn_left, btn_right, btn_sel;
  logic [3:0] row, col;
  logic [6:0] cell_idx;
  logic       load;

  int errors = 0;
  int checks = 0;

  cursor_ctrl #(
    .HOLD_CYCLES  (10),
    .REPEAT_CYCLES(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .btn_sel  (btn_sel),
    .row      (row),
    .col      (col),
    .cell_idx (cell_idx),
    .load     (load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mask bits: 0 up, 1 down, 2 left, 3 right, 4 sel
  task automatic set_btns(input logic [4:0] m);
    {btn_sel, btn_right, btn_left, btn_down, btn_up} = m;
  endtask

  task automatic tap(input logic [4:0] m);
    set_btns(m);
    @(negedge clk);
    set_btns(5'b0);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    set_btns(5'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_btns(5'b01000);
    repeat (3) @(negedge clk);
    checks++; if (row !== 4'd0) begin errors++; $display("FAIL reset_row: got %0d expected 0", row); end
    checks++; if (col !== 4'd0) begin errors++; $display("FAIL reset_col: got %0d expected 0", col); end
    checks++; if (cell_idx !== 7'd0) begin errors++; $display("FAIL reset_cell: got %0d expected 0", cell_idx); end
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL reset_load: got %0b expected 0", load); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (col !== 4'd0) begin errors++; $display("FAIL reset_release_nomove: got col %0d expected 0", col); end
    @(negedge clk);
    checks++; if (col !== 4'd1) begin errors++; $display("FAIL reset_first_move: got col %0d expected 1", col); end
    repeat (5) @(negedge clk);
    set_btns(5'b0);
    repeat (2) @(negedge clk);
    checks++; if (col !== 4'd1 || cell_idx !== 7'd1) begin errors++; $display("FAIL reset_single_move: got col %0d cell %0d expected 1 1", col, cell_idx); end
  endtask

  task automatic test_nav_sel();
    do_reset();
    repeat (3) tap(5'b00010);
    repeat (5) tap(5'b01000);
    checks++; if (row !== 4'd3) begin errors++; $display("FAIL nav_row: got %0d expected 3", row); end
    checks++; if (col !== 4'd5) begin errors++; $display("FAIL nav_col: got %0d expected 5", col); end
    checks++; if (cell_idx !== 7'd32) begin errors++; $display("FAIL nav_cell: got %0d expected 32", cell_idx); end
    set_btns(5'b10000);
    @(negedge clk);
    set_btns(5'b0);
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL sel_early: got load %0b expected 0", load); end
    @(negedge clk);
    checks++; if (load !== 1'b1 || cell_idx !== 7'd32) begin errors++; $display("FAIL sel_load: got load %0b cell %0d expected 1 32", load, cell_idx); end
    @(negedge clk);
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL sel_one_cycle: got load %0b expected 0", load); end
    checks++; if (row !== 4'd3 || col !== 4'd5) begin errors++; $display("FAIL sel_nomove: got row %0d col %0d expected 3 5", row, col); end
  endtask

  task automatic test_wrap();
    do_reset();
    tap(5'b00001);
    checks++; if (row !== 4'd8 || cell_idx !== 7'd72) begin errors++; $display("FAIL wrap_up: got row %0d cell %0d expected 8 72", row, cell_idx); end
    tap(5'b00100);
    checks++; if (col !== 4'd8 || cell_idx !== 7'd80) begin errors++; $display("FAIL wrap_left: got col %0d cell %0d expected 8 80", col, cell_idx); end
    tap(5'b01000);
    checks++; if (col !== 4'd0 || row !== 4'd8 || cell_idx !== 7'd72) begin errors++; $display("FAIL wrap_right: got row %0d col %0d cell %0d expected 8 0 72", row, col, cell_idx); end
    tap(5'b00010);
    checks++; if (row !== 4'd0 || col !== 4'd0 || cell_idx !== 7'd0) begin errors++; $display("FAIL wrap_down: got row %0d col %0d cell %0d expected 0 0 0", row, col, cell_idx); end
  endtask

  task automatic test_priority();
    do_reset();
    repeat (4) tap(5'b00010);
    repeat (4) tap(5'b01000);
    checks++; if (cell_idx !== 7'd40) begin errors++; $display("FAIL prio_setup: got cell %0d expected 40", cell_idx); end
    set_btns(5'b11001);
    @(negedge clk);
    set_btns(5'b0);
    @(negedge clk);
    checks++; if (load !== 1'b1 || cell_idx !== 7'd40) begin errors++; $display("FAIL prio_sel: got load %0b cell %0d expected 1 40", load, cell_idx); end
    repeat (3) @(negedge clk);
    checks++; if (row !== 4'd4 || col !== 4'd4 || load !== 1'b0) begin errors++; $display("FAIL prio_sel_nomove: got row %0d col %0d load %0b expected 4 4 0", row, col, load); end
    tap(5'b01001);
    checks++; if (row !== 4'd3 || col !== 4'd4 || cell_idx !== 7'd31) begin errors++; $display("FAIL prio_up_right: got row %0d col %0d cell %0d expected 3 4 31", row, col, cell_idx); end
  endtask

  task automatic test_hold();
    do_reset();
    set_btns(5'b01000);
    repeat (2) @(negedge clk);
    checks++; if (col !== 4'd1) begin errors++; $display("FAIL hold_first: got col %0d expected 1", col); end
`ifdef CURSOR_AUTOREPEAT_EN
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 9) begin
        checks++; if (col !== 4'd1) begin errors++; $display("FAIL rep_i9: got col %0d expected 1", col); end
      end else if (i == 10) begin
        checks++; if (col !== 4'd2) begin errors++; $display("FAIL rep_i10: got col %0d expected 2", col); end
      end else if (i == 13) begin
        checks++; if (col !== 4'd2) begin errors++; $display("FAIL rep_i13: got col %0d expected 2", col); end
      end else if (i == 14) begin
        checks++; if (col !== 4'd3) begin errors++; $display("FAIL rep_i14: got col %0d expected 3", col); end
      end else if (i == 18) begin
        checks++; if (col !== 4'd4 || cell_idx !== 7'd4) begin errors++; $display("FAIL rep_i18: got col %0d cell %0d expected 4 4", col, cell_idx); end
      end else if (i == 20) begin
        checks++; if (col !== 4'd4) begin errors++; $display("FAIL rep_i20: got col %0d expected 4", col); end
      end
    end
    set_btns(5'b0);
    repeat (2) @(negedge clk);
    checks++; if (dut.state_q !== IDLE || col !== 4'd4) begin errors++; $display("FAIL rep_release: got state %0d col %0d expected 0 4", dut.state_q, col); end
    set_btns(5'b01000);
    repeat (8) @(negedge clk);
`else
    repeat (20) @(negedge clk);
    checks++; if (col !== 4'd1 || cell_idx !== 7'd1) begin errors++; $display("FAIL hold_single: got col %0d cell %0d expected 1 1", col, cell_idx); end
`endif
    reset = 1'b0;
    @(negedge clk);
    set_btns(5'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (col !== 4'd0 || cell_idx !== 7'd0) begin errors++; $display("FAIL hold_reset_col: got col %0d cell %0d expected 0 0", col, cell_idx); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL hold_reset_state: got %0d expected 0", dut.state_q); end
  endtask

  initial begin
    reset = 1'b0;
    set_btns(5'b0);
    @(negedge clk);
    test_reset();
    test_nav_sel();
    test_wrap();
    test_priority();
    test_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
